// File: rtl/seg_defs.sv
// Definitions shared between the digit editor and the four-digit seven-segment driver:
// anode codes, digit range, debounce state encoding and digit wrap helpers.
package seg_defs;

    localparam logic [3:0] ANODE_LEFT  = 4'b1000;
    localparam logic [3:0] ANODE_RIGHT = 4'b0001;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;

    // Bit positions of the buttons inside the packed button vector.
    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;
    localparam int BTN_C = 4;
    localparam int NUM_BTNS = 5;

    typedef enum logic {
        SELECTING  = 1'b0,
        DEBOUNCING = 1'b1
    } db_state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_CLEAR,
        ACT_INC,
        ACT_DEC,
        ACT_LEFT,
        ACT_RIGHT
    } action_t;

    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max_d);
        return (d >= max_d) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] max_d);
        return (d == 4'd0 || d > max_d) ? max_d : d - 4'd1;
    endfunction

    // Slot 0 is the leftmost digit.
    function automatic logic [1:0] anode_to_slot(input logic [3:0] anode);
        case (anode)
            ANODE_LEFT:  return 2'd0;
            4'b0100:     return 2'd1;
            4'b0010:     return 2'd2;
            ANODE_RIGHT: return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button input path: 2-FF synchronizer, debounce FSM with stability counter,
// and a registered one-cycle press pulse on each accepted 0->1 change.
module button_debounce
    import seg_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_meta;
    logic          sync_level;
    logic          accepted;
    logic          accepted_next;
    logic          press_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    db_state_t     state;
    db_state_t     state_next;

    logic differs;
    logic settled;

    assign differs = (sync_level != accepted);
    assign settled = (count == CW'(DEBOUNCE_CYCLES));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
            state      <= SELECTING;
            count      <= '0;
            accepted   <= 1'b0;
            press      <= 1'b0;
        end else begin
            sync_meta  <= raw;
            sync_level <= sync_meta;
            state      <= state_next;
            count      <= count_next;
            accepted   <= accepted_next;
            press      <= press_next;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            SELECTING:  if (differs) state_next = DEBOUNCING;
            DEBOUNCING: if (!differs || settled) state_next = SELECTING;
        endcase
    end

    // The cycle that detects the difference already counts as the first stable cycle.
    always_comb begin
        count_next    = '0;
        accepted_next = accepted;
        press_next    = 1'b0;
        unique case (state)
            SELECTING: begin
                if (differs) count_next = CW'(1);
            end
            DEBOUNCING: begin
                if (differs) begin
                    if (settled) begin
                        accepted_next = sync_level;
                        press_next    = sync_level;
                    end else begin
                        count_next = count + CW'(1);
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/digit_entry.sv
// Button-driven four-digit editor: debounced presses select a slot and edit its 0..MAX_DIGIT
// value, producing the number/currLED pair for the seven-segment driver.
module digit_entry
    import seg_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_DIGIT       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnC,
    output logic [3:0] currLED,
    output logic [3:0] number,
    output logic       entryStrobe
);

    localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);

    logic [NUM_BTNS-1:0] raw_btn;
    logic [NUM_BTNS-1:0] press;

    assign raw_btn = {btnC, btnU, btnD, btnL, btnR};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_btn[i]),
            .press(press[i])
        );
    end

    action_t action;

    always_comb begin
        if      (press[BTN_C]) action = ACT_CLEAR;
        else if (press[BTN_U]) action = ACT_INC;
        else if (press[BTN_D]) action = ACT_DEC;
        else if (press[BTN_L]) action = ACT_LEFT;
        else if (press[BTN_R]) action = ACT_RIGHT;
        else                   action = ACT_NONE;
    end

    logic [3:0] digits [4];
    logic [1:0] sel;
    logic [3:0] led_next;
    logic       wr_en;
    logic [3:0] wr_data;
    logic [3:0] number_next;

    assign sel = anode_to_slot(currLED);

    always_comb begin
        led_next = currLED;
        wr_en    = 1'b0;
        wr_data  = digits[sel];
        case (action)
            ACT_CLEAR: begin
                wr_en   = 1'b1;
                wr_data = 4'd0;
            end
            ACT_INC: begin
                wr_en   = 1'b1;
                wr_data = digit_inc(digits[sel], MAX_D);
            end
            ACT_DEC: begin
                wr_en   = 1'b1;
                wr_data = digit_dec(digits[sel], MAX_D);
            end
            ACT_LEFT:  led_next = {currLED[2:0], currLED[3]};
            ACT_RIGHT: led_next = {currLED[0], currLED[3:1]};
            default: ;
        endcase
    end

    // number follows whichever of the store or the selection changes on this edge.
    assign number_next = wr_en ? wr_data : digits[anode_to_slot(led_next)];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the digit store is reset explicitly because the display shows it straight after reset.
            for (int i = 0; i < 4; i++) digits[i] <= 4'd0;
            currLED     <= ANODE_LEFT;
            number      <= 4'd0;
            entryStrobe <= 1'b0;
        end else begin
            if (wr_en) digits[sel] <= wr_data;
            currLED     <= led_next;
            number      <= number_next;
            entryStrobe <= (action != ACT_NONE);
        end
    end

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry: directed table of presses, multi-cycle corner
// sequences, and randomized button activity checked against a behavioural model.
module tb_digit_entry;

    localparam int N = 4;

    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_R = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0, btnC = 1'b0;
    logic [3:0] currLED;
    logic [3:0] number;
    logic       entryStrobe;

    always #5 clk = ~clk;

    digit_entry #(
        .DEBOUNCE_CYCLES(N),
        .MAX_DIGIT      (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btnL       (btnL),
        .btnR       (btnR),
        .btnU       (btnU),
        .btnD       (btnD),
        .btnC       (btnC),
        .currLED    (currLED),
        .number     (number),
        .entryStrobe(entryStrobe)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_btns(input logic [4:0] m);
        {btnC, btnU, btnD, btnL, btnR} = m;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe pulses counted as sampled at each rising edge.
    int strobe_cnt = 0;
    always @(posedge clk) if (entryStrobe === 1'b1) strobe_cnt++;

    // Behavioural reference: each raw level is seen two edges late; a synchronized level that
    // disagrees with the accepted one for N+1 consecutive edges becomes accepted, and an
    // accepted rise acts on the next edge. The display state is a slot index plus four digits.
    logic [4:0] m_s1 = '0, m_s2 = '0, m_acc = '0, m_press = '0, m_raw;
    int         m_run [5];
    int         m_sel = 0;
    int         m_dig [4];
    logic       m_strobe = 1'b0;

    always @(posedge clk) begin
        m_raw = {btnC, btnU, btnD, btnL, btnR};
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_acc = '0; m_press = '0;
            for (int b = 0; b < 5; b++) m_run[b] = 0;
            for (int s = 0; s < 4; s++) m_dig[s] = 0;
            m_sel = 0;
            m_strobe = 1'b0;
        end else begin
            m_strobe = (m_press != 5'b0);
            if      (m_press[4]) m_dig[m_sel] = 0;
            else if (m_press[3]) m_dig[m_sel] = (m_dig[m_sel] + 1) % 10;
            else if (m_press[2]) m_dig[m_sel] = (m_dig[m_sel] + 9) % 10;
            else if (m_press[1]) m_sel = (m_sel + 3) % 4;
            else if (m_press[0]) m_sel = (m_sel + 1) % 4;
            m_press = '0;
            for (int b = 0; b < 5; b++) begin
                if (m_s2[b] != m_acc[b]) begin
                    m_run[b]++;
                    if (m_run[b] == N + 1) begin
                        m_acc[b]   = m_s2[b];
                        m_press[b] = m_s2[b];
                        m_run[b]   = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = m_raw;
        end
    end

    task automatic model_cycle();
        logic [3:0] e_led;
        @(negedge clk);
        e_led = 4'b1000 >> m_sel;
        check("rand currLED", {28'b0, currLED}, {28'b0, e_led});
        check("rand number", {28'b0, number}, 32'(m_dig[m_sel]));
        check("rand entryStrobe", {31'b0, entryStrobe}, {31'b0, m_strobe});
    endtask

    typedef struct {
        string      name;
        logic [4:0] btn;
        logic [3:0] exp_num;
        logic [3:0] exp_led;
    } vec_t;

    vec_t vecs [20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        // Reset and idle.
        rst = 1'b1;
        tick(3);
        check("reset currLED", {28'b0, currLED}, 32'h8);
        check("reset number", {28'b0, number}, 32'h0);
        check("reset entryStrobe", {31'b0, entryStrobe}, 32'h0);
        rst = 1'b0;
        base = strobe_cnt;
        tick(20);
        check("idle currLED", {28'b0, currLED}, 32'h8);
        check("idle number", {28'b0, number}, 32'h0);
        check("idle strobes", 32'(strobe_cnt - base), 32'h0);

        // Short glitch is dropped.
        base = strobe_cnt;
        set_btns(B_U);
        tick(3);
        set_btns(5'b0);
        tick(12);
        check("glitch number", {28'b0, number}, 32'h0);
        check("glitch strobes", 32'(strobe_cnt - base), 32'h0);

        // Press latency: action on the (N+4)th edge after the raw rise.
        base = strobe_cnt;
        set_btns(B_U);
        tick(N + 3);
        check("latency number before", {28'b0, number}, 32'h0);
        tick(1);
        check("latency number after", {28'b0, number}, 32'h1);
        check("latency strobe high", {31'b0, entryStrobe}, 32'h1);
        tick(1);
        check("latency strobe low", {31'b0, entryStrobe}, 32'h0);
        tick(10 - (N + 5));
        set_btns(5'b0);
        tick(10);
        check("latency strobes", 32'(strobe_cnt - base), 32'h1);

        // Directed press table.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{$sformatf("up to %0d", i + 2), B_U, 4'(i + 2), 4'b1000};
        vecs[8]  = '{"up wrap", B_U, 4'd0, 4'b1000};
        vecs[9]  = '{"down wrap", B_D, 4'd9, 4'b1000};
        vecs[10] = '{"down 8", B_D, 4'd8, 4'b1000};
        vecs[11] = '{"down 7", B_D, 4'd7, 4'b1000};
        vecs[12] = '{"down 6", B_D, 4'd6, 4'b1000};
        vecs[13] = '{"down 5", B_D, 4'd5, 4'b1000};
        vecs[14] = '{"right to slot1", B_R, 4'd0, 4'b0100};
        vecs[15] = '{"left to slot0", B_L, 4'd5, 4'b1000};
        vecs[16] = '{"left wrap", B_L, 4'd0, 4'b0001};
        vecs[17] = '{"right wrap", B_R, 4'd5, 4'b1000};
        vecs[18] = '{"up 6", B_U, 4'd6, 4'b1000};
        vecs[19] = '{"up 7", B_U, 4'd7, 4'b1000};
        for (int i = 0; i < 20; i++) begin
            base = strobe_cnt;
            set_btns(vecs[i].btn);
            tick(10);
            set_btns(5'b0);
            tick(10);
            check({vecs[i].name, " number"}, {28'b0, number}, {28'b0, vecs[i].exp_num});
            check({vecs[i].name, " currLED"}, {28'b0, currLED}, {28'b0, vecs[i].exp_led});
            check({vecs[i].name, " strobes"}, 32'(strobe_cnt - base), 32'h1);
        end

        // C and U together on a 7: clear wins, one strobe.
        base = strobe_cnt;
        set_btns(B_C | B_U);
        tick(10);
        set_btns(5'b0);
        tick(10);
        check("C+U number", {28'b0, number}, 32'h0);
        check("C+U strobes", 32'(strobe_cnt - base), 32'h1);

        // Held button acts once.
        base = strobe_cnt;
        set_btns(B_U);
        tick(40);
        set_btns(5'b0);
        tick(12);
        check("held number", {28'b0, number}, 32'h1);
        check("held strobes", 32'(strobe_cnt - base), 32'h1);

        // Bring slot 0 to 3, then reset mid-debounce of D and keep D held.
        repeat (2) begin
            set_btns(B_U); tick(10); set_btns(5'b0); tick(10);
        end
        check("preset 3", {28'b0, number}, 32'h3);
        base = strobe_cnt;
        set_btns(B_D);
        tick(4);
        rst = 1'b1;
        tick(2);
        check("midreset currLED", {28'b0, currLED}, 32'h8);
        check("midreset number", {28'b0, number}, 32'h0);
        check("midreset strobe", {31'b0, entryStrobe}, 32'h0);
        rst = 1'b0;
        tick(N + 3);
        check("held-through-reset before", {28'b0, number}, 32'h0);
        check("held-through-reset no strobe", 32'(strobe_cnt - base), 32'h0);
        tick(1);
        check("held-through-reset number", {28'b0, number}, 32'h9);
        check("held-through-reset strobe", {31'b0, entryStrobe}, 32'h1);
        set_btns(5'b0);
        tick(12);

        // Randomized activity against the reference model.
        for (int s = 0; s < 250; s++) begin
            logic [4:0] mask;
            int hold, gap;
            if ($urandom_range(0, 9) < 7) mask = 5'(1 << $urandom_range(0, 4));
            else                           mask = 5'($urandom_range(0, 31));
            hold = $urandom_range(1, 12);
            gap  = $urandom_range(1, 12);
            set_btns(mask);
            repeat (hold) model_cycle();
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                repeat (2) model_cycle();
                rst = 1'b0;
            end
            set_btns(5'b0);
            repeat (gap) model_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
